// File: rtl/controle_bobc_pkg.sv
// Shared encodings for the BOBC polynomial controller and datapath:
// FSM states, mux selects and ULA operation codes.
package bobc_pkg;

  localparam logic H_ADD = 1'b0;
  localparam logic H_MUL = 1'b1;

  // m0: operand mux
  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_A    = 2'b01;
  localparam logic [1:0] SEL_B    = 2'b10;
  localparam logic [1:0] SEL_C    = 2'b11;

  // m1: ULA left input
  localparam logic [1:0] M1_OUTM0 = 2'b00;
  localparam logic [1:0] M1_X     = 2'b01;
  localparam logic [1:0] M1_S     = 2'b10;
  localparam logic [1:0] M1_H     = 2'b11;

  // m2: ULA right input
  localparam logic [1:0] M2_X     = 2'b00;
  localparam logic [1:0] M2_OUTM0 = 2'b01;
  localparam logic [1:0] M2_S     = 2'b10;
  localparam logic [1:0] M2_H     = 2'b11;

  // Legacy state codes kept so existing datapath debug taps still decode them.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_X = 3'd1;
  localparam logic [2:0] ST_MUL_AX = 3'd2;
  localparam logic [2:0] ST_ADD_B  = 3'd3;
  localparam logic [2:0] ST_MUL_X  = 3'd4;
  localparam logic [2:0] ST_ADD_C  = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD_X = ST_LOAD_X,
    MUL_AX = ST_MUL_AX,
    ADD_B  = ST_ADD_B,
    MUL_X  = ST_MUL_X,
    ADD_C  = ST_ADD_C,
    DONE   = ST_DONE
  } state_t;

  typedef struct packed {
    logic       lx;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       h;
    logic       ls;
    logic       lh;
    logic       done;
    logic       busy;
  } ctrl_t;

endpackage

// File: rtl/controle_bobc_if.sv
// Control bus between controle_bobc and the BOBC datapath / requester.
// master: the controller side; slave: the datapath and start requester.
interface controle_bobc_if;

  logic       start;
  logic       lx;
  logic [1:0] m0;
  logic [1:0] m1;
  logic [1:0] m2;
  logic       h;
  logic       ls;
  logic       lh;
  logic       done;
  logic       busy;

  modport master (
    input  start,
    output lx, m0, m1, m2, h, ls, lh, done, busy
  );

  modport slave (
    output start,
    input  lx, m0, m1, m2, h, ls, lh, done, busy
  );

endinterface

// File: rtl/controle_bobc.sv
// Moore controller sequencing the BOBC datapath through ((A*X)+B)*X + C;
// all controls decode from the registered state.
module controle_bobc
  import bobc_pkg::*;
(
  input  logic              ck,
  input  logic              rst,
  controle_bobc_if.master   bus
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctl;

  always_ff @(posedge ck) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = bus.start ? LOAD_X : IDLE;
      LOAD_X:  state_d = MUL_AX;
      MUL_AX:  state_d = ADD_B;
      ADD_B:   state_d = MUL_X;
      MUL_X:   state_d = ADD_C;
      ADD_C:   state_d = DONE;
      DONE:    state_d = bus.start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctl    = '0;
    ctl.m0 = SEL_ZERO;
    ctl.m1 = M1_OUTM0;
    ctl.m2 = M2_X;
    ctl.h  = H_ADD;
    case (state_q)
      LOAD_X: begin
        ctl.lx   = 1'b1;
        ctl.busy = 1'b1;
      end
      MUL_AX: begin
        ctl.m0   = SEL_A;
        ctl.m1   = M1_OUTM0;
        ctl.m2   = M2_X;
        ctl.h    = H_MUL;
        ctl.lh   = 1'b1;
        ctl.busy = 1'b1;
      end
      ADD_B: begin
        ctl.m0   = SEL_B;
        ctl.m1   = M1_H;
        ctl.m2   = M2_OUTM0;
        ctl.h    = H_ADD;
        ctl.lh   = 1'b1;
        ctl.busy = 1'b1;
      end
      MUL_X: begin
        ctl.m1   = M1_H;
        ctl.m2   = M2_X;
        ctl.h    = H_MUL;
        ctl.lh   = 1'b1;
        ctl.busy = 1'b1;
      end
      ADD_C: begin
        ctl.m0   = SEL_C;
        ctl.m1   = M1_H;
        ctl.m2   = M2_OUTM0;
        ctl.h    = H_ADD;
        ctl.ls   = 1'b1;
        ctl.busy = 1'b1;
      end
      // Resultado shows Reg_S + 0 while the result is held.
      DONE: begin
        ctl.m0   = SEL_ZERO;
        ctl.m1   = M1_S;
        ctl.m2   = M2_OUTM0;
        ctl.h    = H_ADD;
        ctl.done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.lx   = ctl.lx;
  assign bus.m0   = ctl.m0;
  assign bus.m1   = ctl.m1;
  assign bus.m2   = ctl.m2;
  assign bus.h    = ctl.h;
  assign bus.ls   = ctl.ls;
  assign bus.lh   = ctl.lh;
  assign bus.done = ctl.done;
  assign bus.busy = ctl.busy;

endmodule

// File: tb/tb_controle_bobc.sv
// Bench for controle_bobc: drives a behavioural BOBC datapath from the control
// outputs and compares against a closed-form polynomial and a per-cycle schedule.
module tb_controle_bobc;

  logic ck;
  logic rst;
  controle_bobc_if bus ();

  controle_bobc dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  // Behavioural datapath driven by the controller's outputs.
  logic [15:0] x_in, a_in, b_in, c_in;
  logic [15:0] reg_x, reg_h, reg_s;
  logic [15:0] outm0, left_op, right_op, resultado;

  always_comb begin
    case (bus.m0)
      2'b00:   outm0 = 16'h0000;
      2'b01:   outm0 = a_in;
      2'b10:   outm0 = b_in;
      default: outm0 = c_in;
    endcase
    case (bus.m1)
      2'b00:   left_op = outm0;
      2'b01:   left_op = reg_x;
      2'b10:   left_op = reg_s;
      default: left_op = reg_h;
    endcase
    case (bus.m2)
      2'b00:   right_op = reg_x;
      2'b01:   right_op = outm0;
      2'b10:   right_op = reg_s;
      default: right_op = reg_h;
    endcase
    resultado = bus.h ? 16'(left_op * right_op) : 16'(left_op + right_op);
  end

  always @(posedge ck) begin
    if (bus.lx) reg_x <= x_in;
    if (bus.lh) reg_h <= resultado;
    if (bus.ls) reg_s <= resultado;
  end

  logic [11:0] vec;
  assign vec = {bus.lx, bus.m0, bus.m1, bus.m2, bus.h, bus.ls, bus.lh, bus.done, bus.busy};

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected {lx,m0,m1,m2,h,ls,lh,done,busy} k edges after start is raised in IDLE.
  function automatic logic [11:0] exp_vec(input int k);
    case (k)
      1:       return 12'b1_00_00_00_0_0_0_0_1;
      2:       return 12'b0_01_00_00_1_0_1_0_1;
      3:       return 12'b0_10_11_01_0_0_1_0_1;
      4:       return 12'b0_00_11_00_1_0_1_0_1;
      5:       return 12'b0_11_11_01_0_1_0_0_1;
      6:       return 12'b0_00_10_01_0_0_0_1_0;
      default: return 12'b0;
    endcase
  endfunction

  function automatic logic [15:0] poly(input logic [15:0] x, a, b, c);
    longint unsigned xl, r;
    xl = longint'(x);
    r  = longint'(a) * xl * xl + longint'(b) * xl + longint'(c);
    return r[15:0];
  endfunction

  task automatic run_calc(input logic [15:0] x, a, b, c, input int unsigned hold);
    logic [15:0] expect_r;
    x_in = x; a_in = a; b_in = b; c_in = c;
    expect_r = poly(x, a, b, c);
    bus.start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("ctrl_vec_k%0d", k), 32'(vec), 32'(exp_vec(k)));
    end
    chk("resultado", 32'(resultado), 32'(expect_r));
    for (int unsigned i = 0; i < hold; i++) begin
      tick();
      chk("hold_done", 32'(bus.done), 32'd1);
      chk("hold_no_lx", 32'(bus.lx), 32'd0);
    end
    if (hold > 0) chk("hold_result", 32'(resultado), 32'(expect_r));
    bus.start = 1'b0;
    tick();
    chk("idle_after_done", 32'(vec), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    x_in = '0; a_in = '0; b_in = '0; c_in = '0;
    tick();
    tick();
    chk("reset_vec", 32'(vec), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_vec", 32'(vec), 32'd0);

    run_calc(16'd2, 16'd3, 16'd4, 16'd5, 10);
    chk("known_25", 32'(reg_s), 32'h0019);
    run_calc(16'd0, 16'd7, 16'd9, 16'h1234, 0);
    chk("x_zero", 32'(reg_s), 32'h1234);
    run_calc(16'h0100, 16'd1, 16'd0, 16'd3, 1);
    chk("wrap", 32'(reg_s), 32'h0003);

    // Reset while ADD_B is active: no further load pulses, back to IDLE.
    x_in = 16'd11; a_in = 16'd13; b_in = 16'd17; c_in = 16'd19;
    bus.start = 1'b1;
    for (int k = 1; k <= 3; k++) tick();
    chk("pre_reset_add_b", 32'(vec), 32'(exp_vec(3)));
    rst = 1'b1;
    bus.start = 1'b0;
    tick();
    chk("mid_reset_vec", 32'(vec), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_reset_idle", 32'(vec), 32'd0);
    run_calc(16'd11, 16'd13, 16'd17, 16'd19, 2);

    // rst and start together: IDLE first, start taken on the following edge.
    rst = 1'b1;
    bus.start = 1'b1;
    tick();
    chk("rst_start_idle", 32'(vec), 32'd0);
    rst = 1'b0;
    run_calc(16'd5, 16'd6, 16'd7, 16'd8, 0);

    for (int t = 0; t < 8; t++) begin
      run_calc(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
               $urandom_range(0, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
